alu_md_control: RTL and testbench
=================================

ALU_MD_CONTROL -- requirements
Module: alu_md_control

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of operands and HI/LO; legal 8..64, even.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, iteration counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 alu_op  input  2  main-decoder class: 00 add, 01 sub, 10 R-type (use func), 11 slt.
REQ-006 func  input  6  R-type function field.
REQ-007 issue  input  1  instruction valid in EX this cycle.
REQ-008 op_a, op_b  input  WIDTH each  rs / rt operand values.
REQ-009 alu_operation  output  3  ALU select, combinational.
REQ-010 jr  output  1  jump-register indication, combinational.
REQ-011 mf_sel  output  2  writeback source: 00 ALU, 01 HI, 10 LO.
REQ-012 stall  output  1  hold pipeline this cycle, combinational.
REQ-013 md_busy  output  1  multiply/divide engine active, registered.
REQ-014 hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-015 alu_op 00->010, 01->011, 11->111; 10 decodes func: 36->000 and, 37->001 or, 32/33->010 add, 34/35->011 sub, 42->111 slt, 43->110 sltu, 38->100 xor, 39->101 nor; any other code->000.
REQ-016 jr=1 iff alu_op=10 and func=8; alu_operation irrelevant then.
REQ-017 mf_sel=01 for func 16 (mfhi), 10 for func 18 (mflo), else 00; only when alu_op=10.
REQ-018 MD ops (alu_op=10): 24 mult, 25 multu, 26 div, 27 divu, 17 mthi, 19 mtlo.
REQ-019 FSM states IDLE, MUL, DIV, FIX; accept = issue & MD op & state IDLE & !stall.
REQ-020 IDLE: mthi/mtlo accepted write op_a to HI/LO at next edge, no busy.
REQ-021 IDLE: mult(u)->MUL, div(u)->DIV; latch |op_a|,|op_b| (signed ops) or raw values, result signs, counter=0.
REQ-022 MUL: shift-add, one operand bit per cycle, WIDTH cycles; then FIX.
REQ-023 DIV: restoring, one quotient bit per cycle, WIDTH cycles; then FIX.
REQ-024 FIX: one cycle; negate product if signs differ (mult); negate quotient if signs differ, remainder takes dividend sign (div); write HI/LO; ->IDLE.
REQ-025 Results: mult -> {HI,LO}=2*WIDTH-bit product; div -> LO=quotient, HI=remainder.
REQ-026 Divide by zero: LO=all ones, HI=op_a as issued; takes full latency, no exception.
REQ-027 md_busy=1 from edge after accept through FIX cycle inclusive: WIDTH+1 cycles; HI/LO new value visible cycle after FIX.
REQ-028 stall=1 when issue & md_busy & func in {16,17,18,19,24,25,26,27}; other instructions proceed.
REQ-029 HI/LO hold value in all states except IDLE mt-write and FIX.
REQ-030 signed most-negative / -1 divide: quotient wraps to most-negative, remainder 0.

Reset
REQ-031 rst asserted: state IDLE, hi=0, lo=0, md_busy=0, counter=0, internal operands 0, immediately (async).
REQ-032 rst mid-operation aborts the computation; HI/LO read 0, no partial result written.
REQ-033 Deassertion: first accept possible on first rising edge after rst low.

Structure
REQ-034 Shared package holds func codes, alu_operation encodings, mf_sel encodings, FSM state typedef.
REQ-035 Decode (REQ-015..018) combinational in top; one sub-module md_engine holds FSM, counter, shift registers, HI/LO.

Verification
REQ-036 alu_op=10 sweep all 64 func -> alu_operation/jr/mf_sel per REQ-015..017; func 8 -> jr=1.
REQ-037 multu 0xFFFFFFFF*0xFFFFFFFF -> md_busy 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
REQ-038 mult -7*3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-039 divu 100/0 -> LO=0xFFFFFFFF, HI=100; mflo issued while busy -> stall=1 until FIX done, then mf_sel=10.
REQ-040 rst pulse at cycle 10 of mult -> md_busy=0, hi=lo=0, next mthi 0x1234 -> hi=0x1234.
REQ-041 add issued during busy -> stall=0, alu_operation=010; second mult during busy -> stall=1, accepted after FIX.

Source files
------------

// File: rtl/alu_md_control_pkg.sv
// Shared encodings for the EX-stage ALU decoder and the multiply/divide engine:
// R-type function codes, ALU selects, writeback-source selects and engine states.
package alu_md_control_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  localparam logic [5:0] FN_JR    = 6'd8;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MTHI  = 6'd17;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MTLO  = 6'd19;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_ADDU  = 6'd33;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SUBU  = 6'd35;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_XOR   = 6'd38;
  localparam logic [5:0] FN_NOR   = 6'd39;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SLTU  = 6'd43;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [1:0] MF_ALU = 2'b00;
  localparam logic [1:0] MF_HI  = 2'b01;
  localparam logic [1:0] MF_LO  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIX  = 2'b11
  } md_state_e;

  // Instructions that read or write HI/LO and therefore must wait for the engine.
  function automatic logic is_hilo_hazard(input logic [5:0] f);
    return f inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                     FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  endfunction

endpackage

// File: rtl/alu_md_control_md_engine.sv
// Iterative multiply (shift-add) / divide (restoring) engine owning HI/LO.
// One operand bit per cycle, then a single sign-fixup cycle that writes HI/LO.
module alu_md_control_md_engine
  import alu_md_control_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic             is_signed,
  input  logic             write_hi,
  input  logic             write_lo,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             md_busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  md_state_e          state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   den_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic               div_zero_reg;
  logic               is_div_reg;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // acc_reg holds {partial product, unused multiplier bits}; add on the LSB, shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc_reg[0] ? den_reg : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

  // acc_reg holds {partial remainder, dividend/quotient bits}; trial-subtract after shift left.
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  assign div_diff = acc_reg[2*WIDTH-1:WIDTH-1] - {1'b0, den_reg};
  assign div_next = div_diff[WIDTH] ? {acc_reg[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;
  assign quo_fix  = div_zero_reg ? {WIDTH{1'b1}}
                  : (neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0]);
  assign rem_fix  = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      den_reg      <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      is_div_reg   <= 1'b0;
      md_busy      <= 1'b0;
      hi           <= '0;
      lo           <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (write_hi) hi <= op_a;
          if (write_lo) lo <= op_a;
          if (start_mul || start_div) begin
            state_reg    <= start_div ? ST_DIV : ST_MUL;
            md_busy      <= 1'b1;
            cnt_reg      <= '0;
            is_div_reg   <= start_div;
            neg_q_reg    <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            neg_r_reg    <= is_signed && op_a[WIDTH-1];
            div_zero_reg <= start_div && (op_b == '0);
            if (start_div) begin
              acc_reg <= {{WIDTH{1'b0}}, mag(op_a, is_signed)};
              den_reg <= mag(op_b, is_signed);
            end else begin
              acc_reg <= {{WIDTH{1'b0}}, mag(op_b, is_signed)};
              den_reg <= mag(op_a, is_signed);
            end
          end
        end
        ST_MUL: begin
          acc_reg <= mul_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST) state_reg <= ST_FIX;
        end
        ST_DIV: begin
          acc_reg <= div_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST) state_reg <= ST_FIX;
        end
        ST_FIX: begin
          if (is_div_reg) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          state_reg <= ST_IDLE;
          md_busy   <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_md_control.sv
// EX-stage ALU control: combinational ALU/jr/writeback-source decode, HI/LO
// hazard stall, and the issue handshake into the multiply/divide engine.
module alu_md_control
  import alu_md_control_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func,
  input  logic             issue,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [2:0]       alu_operation,
  output logic             jr,
  output logic [1:0]       mf_sel,
  output logic             stall,
  output logic             md_busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic rtype;
  assign rtype = (alu_op == ALUOP_RTYPE);

  always_comb begin
    alu_operation = ALU_AND;
    jr            = 1'b0;
    mf_sel        = MF_ALU;
    case (alu_op)
      ALUOP_ADD: alu_operation = ALU_ADD;
      ALUOP_SUB: alu_operation = ALU_SUB;
      ALUOP_SLT: alu_operation = ALU_SLT;
      default: begin
        case (func)
          FN_AND:          alu_operation = ALU_AND;
          FN_OR:           alu_operation = ALU_OR;
          FN_ADD, FN_ADDU: alu_operation = ALU_ADD;
          FN_SUB, FN_SUBU: alu_operation = ALU_SUB;
          FN_SLT:          alu_operation = ALU_SLT;
          FN_SLTU:         alu_operation = ALU_SLTU;
          FN_XOR:          alu_operation = ALU_XOR;
          FN_NOR:          alu_operation = ALU_NOR;
          default:         alu_operation = ALU_AND;
        endcase
        jr = (func == FN_JR);
        if (func == FN_MFHI)      mf_sel = MF_HI;
        else if (func == FN_MFLO) mf_sel = MF_LO;
      end
    endcase
  end

  // md_busy is low exactly when the engine is idle, so it doubles as the idle qualifier.
  logic accept;
  assign stall  = issue && md_busy && rtype && is_hilo_hazard(func);
  assign accept = issue && rtype && !md_busy && !stall;

  logic start_mul;
  logic start_div;
  logic is_signed;
  logic write_hi;
  logic write_lo;
  assign start_mul = accept && (func == FN_MULT || func == FN_MULTU);
  assign start_div = accept && (func == FN_DIV  || func == FN_DIVU);
  assign is_signed = (func == FN_MULT) || (func == FN_DIV);
  assign write_hi  = accept && (func == FN_MTHI);
  assign write_lo  = accept && (func == FN_MTLO);

  alu_md_control_md_engine #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) md_engine (
    .clk      (clk),
    .rst      (rst),
    .start_mul(start_mul),
    .start_div(start_div),
    .is_signed(is_signed),
    .write_hi (write_hi),
    .write_lo (write_lo),
    .op_a     (op_a),
    .op_b     (op_b),
    .md_busy  (md_busy),
    .hi       (hi),
    .lo       (lo)
  );

endmodule

// File: tb/tb_alu_md_control.sv
// Self-checking bench for alu_md_control: decode sweep plus multiply/divide
// results checked against a scoreboard fed by a native-arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_md_control;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   alu_op;
  logic [5:0]   func;
  logic         issue;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [2:0]   alu_operation;
  logic         jr;
  logic [1:0]   mf_sel;
  logic         stall;
  logic         md_busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  alu_md_control #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .alu_op(alu_op), .func(func), .issue(issue),
    .op_a(op_a), .op_b(op_b), .alu_operation(alu_operation), .jr(jr),
    .mf_sel(mf_sel), .stall(stall), .md_busy(md_busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_alu(input logic [5:0] f);
    case (f)
      6'd36:        return 3'b000;
      6'd37:        return 3'b001;
      6'd32, 6'd33: return 3'b010;
      6'd34, 6'd35: return 3'b011;
      6'd42:        return 3'b111;
      6'd43:        return 3'b110;
      6'd38:        return 3'b100;
      6'd39:        return 3'b101;
      default:      return 3'b000;
    endcase
  endfunction

  // Reference {HI,LO} from native 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint m;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (f)
      6'd24: r = sa * sb;
      6'd25: r = {32'd0, a} * {32'd0, b};
      6'd26: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else        r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  task automatic issue_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit push);
    alu_op = 2'b10; func = f; op_a = a; op_b = b; issue = 1'b1;
    if (push) exp_q.push_back(model(f, a, b));
    step();
    issue = 1'b0; alu_op = 2'b00; func = 6'd0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (md_busy === 1'b1 && cycles < 200) begin
      cycles++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; issue = 1'b0; alu_op = 2'b00; func = 6'd0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
    n_tests++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
    n_tests++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", md_busy); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");
  endtask

  task automatic test_decode();
    logic [1:0] mf_exp;
    for (int op = 0; op < 4; op++) begin
      if (op == 2) continue;
      alu_op = 2'(op); func = 6'($urandom_range(0, 63)); #1;
      n_tests++;
      if (alu_operation !== ((op == 0) ? 3'b010 : (op == 1) ? 3'b011 : 3'b111)) begin
        n_fail++; $display("FAIL decode_aluop op=%0d got %b", op, alu_operation);
      end
    end
    for (int f = 0; f < 64; f++) begin
      alu_op = 2'b10; func = 6'(f); #1;
      mf_exp = (f == 16) ? 2'b01 : (f == 18) ? 2'b10 : 2'b00;
      if (f != 8) begin
        n_tests++;
        if (alu_operation !== exp_alu(6'(f))) begin
          n_fail++; $display("FAIL decode_op func=%0d got %b want %b", f, alu_operation, exp_alu(6'(f)));
        end
      end
      n_tests++;
      if (jr !== (f == 8)) begin n_fail++; $display("FAIL decode_jr func=%0d got %b", f, jr); end
      n_tests++;
      if (mf_sel !== mf_exp) begin n_fail++; $display("FAIL decode_mf func=%0d got %b want %b", f, mf_sel, mf_exp); end
    end
    alu_op = 2'b00; func = 6'd0; #1;
    $display("[TB] decode sweep done");
  endtask

  task automatic test_multu();
    int cyc;
    logic [63:0] exp;
    issue_md(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_idle(cyc);
    n_tests++; if (cyc != 33) begin n_fail++; $display("FAIL multu_latency got %0d want 33", cyc); end
    if (exp_q.size() != 0) exp = exp_q.pop_front(); else exp = 'x;
    n_tests++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL multu_sb got %h%h want %h", hi, lo, exp); end
    n_tests++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      n_fail++; $display("FAIL multu_const got %h_%h want fffffffe_00000001", hi, lo);
    end
    $display("[TB] multu ffffffff*ffffffff -> hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_signed();
    logic [5:0]  t_f[3]  = '{6'd24, 6'd26, 6'd26};
    logic [31:0] t_a[3]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] t_b[3]  = '{32'd3, 32'd2, 32'hFFFF_FFFF};
    logic [63:0] t_hl[3] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_8000_0000};
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int cyc;
    for (int i = 0; i < 11; i++) begin
      if (i < 3) begin
        f = t_f[i]; a = t_a[i]; b = t_b[i];
      end else begin
        f = 6'(24 + (i % 4)); a = $urandom;
        b = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
        if (i % 5 == 0) b = -b;
      end
      issue_md(f, a, b, 1'b1);
      wait_idle(cyc);
      if (exp_q.size() != 0) exp = exp_q.pop_front(); else exp = 'x;
      n_tests++;
      if ({hi, lo} !== exp || cyc != 33) begin
        n_fail++; $display("FAIL md_sb func=%0d a=%h b=%h got %h%h cyc=%0d want %h cyc=33", f, a, b, hi, lo, cyc, exp);
      end
      if (i < 3) begin
        n_tests++;
        if ({hi, lo} !== t_hl[i]) begin
          n_fail++; $display("FAIL md_const func=%0d got %h%h want %h", f, hi, lo, t_hl[i]);
        end
      end
      $display("[TB] func=%0d a=%h b=%h -> hi=%h lo=%h", f, a, b, hi, lo);
    end
  endtask

  task automatic test_divzero_stall();
    int cyc;
    logic [63:0] exp;
    issue_md(6'd27, 32'd100, 32'd0, 1'b1);
    alu_op = 2'b10; func = 6'd18; issue = 1'b1; #1;
    cyc = 0;
    while (md_busy === 1'b1 && cyc < 200) begin
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mflo_stall cyc=%0d got %b want 1", cyc, stall); end
      cyc++;
      step();
    end
    n_tests++; if (cyc != 33) begin n_fail++; $display("FAIL divzero_latency got %0d want 33", cyc); end
    n_tests++; if (stall !== 1'b0 || mf_sel !== 2'b10) begin
      n_fail++; $display("FAIL mflo_release got stall=%b mf_sel=%b want 0/10", stall, mf_sel);
    end
    if (exp_q.size() != 0) exp = exp_q.pop_front(); else exp = 'x;
    n_tests++; if ({hi, lo} !== exp || hi !== 32'd100 || lo !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL divzero got %h_%h want %h", hi, lo, exp);
    end
    issue = 1'b0; alu_op = 2'b00; func = 6'd0;
    $display("[TB] divu 100/0 -> hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_rst_abort();
    issue_md(6'd24, 32'd12345, 32'd6789, 1'b0);
    repeat (9) step();
    n_tests++; if (hi !== 32'd100 || md_busy !== 1'b1) begin
      n_fail++; $display("FAIL hold_mid_op got hi=%h busy=%b want 00000064/1", hi, md_busy);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (md_busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("FAIL rst_abort got busy=%b hi=%h lo=%h want 0/0/0", md_busy, hi, lo);
    end
    @(negedge clk);
    rst = 1'b0;
    alu_op = 2'b10; func = 6'd17; op_a = 32'h1234; issue = 1'b1;
    step();
    n_tests++; if (hi !== 32'h1234 || md_busy !== 1'b0) begin
      n_fail++; $display("FAIL mthi got hi=%h busy=%b want 00001234/0", hi, md_busy);
    end
    func = 6'd19; op_a = 32'h5678;
    step();
    issue = 1'b0; alu_op = 2'b00; func = 6'd0;
    n_tests++; if (lo !== 32'h5678 || hi !== 32'h1234) begin
      n_fail++; $display("FAIL mtlo got hi=%h lo=%h want 00001234/00005678", hi, lo);
    end
    $display("[TB] reset abort then mthi/mtlo -> hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [63:0] exp;
    issue_md(6'd24, 32'd1000, 32'hFFFF_FFFD, 1'b1);
    step(); step();
    alu_op = 2'b10; func = 6'd32; issue = 1'b1; #1;
    n_tests++; if (stall !== 1'b0 || alu_operation !== 3'b010) begin
      n_fail++; $display("FAIL add_during_busy got stall=%b op=%b want 0/010", stall, alu_operation);
    end
    func = 6'd25; op_a = 32'hDEAD_BEEF; op_b = 32'h0001_0003;
    exp_q.push_back(model(6'd25, op_a, op_b));
    #1;
    cyc = 0;
    while (md_busy === 1'b1 && cyc < 200) begin
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mult_stall cyc=%0d got %b want 1", cyc, stall); end
      cyc++;
      step();
    end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mult_release got stall=%b want 0", stall); end
    if (exp_q.size() != 0) exp = exp_q.pop_front(); else exp = 'x;
    n_tests++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL b2b_first got %h%h want %h", hi, lo, exp); end
    step();
    issue = 1'b0; alu_op = 2'b00; func = 6'd0;
    n_tests++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got busy=%b want 1", md_busy); end
    wait_idle(cyc);
    if (exp_q.size() != 0) exp = exp_q.pop_front(); else exp = 'x;
    n_tests++; if ({hi, lo} !== exp || cyc != 33) begin
      n_fail++; $display("FAIL b2b_second got %h%h cyc=%0d want %h cyc=33", hi, lo, cyc, exp);
    end
    $display("[TB] back-to-back mult/multu -> hi=%h lo=%h", hi, lo);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_multu();
    test_signed();
    test_divzero_stall();
    test_rst_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
